axil_ram_slave: RTL and testbench

AXI4-Lite subordinate that terminates one device port of the AXI-Lite interconnect and serves a word-addressed, byte-writable on-chip RAM. It accepts independent AW/W/AR handshakes, commits writes with byte strobes, returns read data one cycle after the AR handshake, and signals misaligned accesses with SLVERR. One instance sits on each `s_*` device slot of the interconnect.

---
 rtl/axil_pkg.sv | 24 ++
 rtl/axil_ram_mem.sv | 34 +++
 rtl/axil_ram_slave.sv | 207 ++++++++++++++++++++
 tb/tb_axil_ram_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite RAM subordinate.
// Response codes and the write/read FSM state encodings.
package axil_pkg;

  localparam int RespWidth = 2;

  typedef enum logic [RespWidth-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axil_ram_mem.sv
// Word RAM with a byte-enabled write port and a registered read port.
// Both ports act on the same edge; a same-word read sees the old data.
module axil_ram_mem
  import axil_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int MemDepth  = 1024
) (
  input  logic                         clk_i,
  input  logic [DataWidth/8-1:0]       we,
  input  logic [$clog2(MemDepth)-1:0]  waddr,
  input  logic [DataWidth-1:0]         wdata,
  input  logic                         re,
  input  logic [$clog2(MemDepth)-1:0]  raddr,
  output logic [DataWidth-1:0]         rdata
);

  localparam int StrbW = DataWidth / 8;

  logic [DataWidth-1:0] mem [MemDepth];

  // Array contents carry no reset so the RAM maps onto block memory.
  always_ff @(posedge clk_i) begin
    if (re) begin
      rdata <= mem[raddr];
    end
    for (int i = 0; i < StrbW; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite subordinate serving a byte-writable word RAM.
// Independent write and read FSMs; every output comes from a flop.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int MemDepth     = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [AddressWidth-1:0]  s_awaddr,
  input  logic [2:0]               s_awprot,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  input  logic [DataWidth-1:0]     s_wdata,
  input  logic [DataWidth/8-1:0]   s_wstrb,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  output logic [1:0]               s_bresp,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  input  logic [AddressWidth-1:0]  s_araddr,
  input  logic [2:0]               s_arprot,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [DataWidth-1:0]     s_rdata,
  output logic [1:0]               s_rresp
);

  localparam int StrbW = DataWidth / 8;
  localparam int Lsb   = $clog2(StrbW);
  localparam int IdxW  = $clog2(MemDepth);

  wr_state_e wst_q, wst_d;
  logic aw_held_q, aw_held_d;
  logic [AddressWidth-1:0] aw_addr_q, aw_addr_d;
  logic w_held_q, w_held_d;
  logic [DataWidth-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0] w_strb_q, w_strb_d;
  logic awrdy_q, awrdy_d;
  logic wrdy_q, wrdy_d;
  logic bvalid_q, bvalid_d;
  axil_resp_e bresp_q, bresp_d;

  logic aw_hs, w_hs, commit, wr_misal;
  logic [AddressWidth-1:0] wa_addr;
  logic [DataWidth-1:0] wa_data;
  logic [StrbW-1:0] wa_strb, mem_we;

  rd_state_e rdst_q, rdst_d;
  logic arrdy_q, arrdy_d;
  logic rvalid_q, rvalid_d;
  axil_resp_e rresp_q, rresp_d;
  logic ar_hs, rd_misal;
  logic [DataWidth-1:0] mem_rdata;

  assign aw_hs = s_awvalid && awrdy_q;
  assign w_hs  = s_wvalid && wrdy_q;

  // A beat handshaking this cycle counts as available alongside a held one.
  assign wa_addr = aw_held_q ? aw_addr_q : s_awaddr;
  assign wa_data = w_held_q ? w_data_q : s_wdata;
  assign wa_strb = w_held_q ? w_strb_q : s_wstrb;

  assign wr_misal = |wa_addr[Lsb-1:0];
  assign commit = (wst_q == W_COLLECT)
               && (aw_held_q || aw_hs)
               && (w_held_q || w_hs);
  assign mem_we = (commit && !wr_misal) ? wa_strb : '0;

  always_comb begin
    wst_d     = wst_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (wst_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s_wdata;
          w_strb_d = s_wstrb;
        end
        if (commit) begin
          wst_d    = W_RESP;
          bvalid_d = 1'b1;
          bresp_d  = wr_misal ? SLVERR : OKAY;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          wst_d     = W_COLLECT;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: wst_d = W_COLLECT;
    endcase
    awrdy_d = (wst_d == W_COLLECT) && !aw_held_d;
    wrdy_d  = (wst_d == W_COLLECT) && !w_held_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wst_q     <= W_COLLECT;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awrdy_q   <= 1'b0;
      wrdy_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      wst_q     <= wst_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awrdy_q   <= awrdy_d;
      wrdy_q    <= wrdy_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign ar_hs    = s_arvalid && arrdy_q;
  assign rd_misal = |s_araddr[Lsb-1:0];

  always_comb begin
    rdst_d   = rdst_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    unique case (rdst_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdst_d   = R_DATA;
          rvalid_d = 1'b1;
          rresp_d  = rd_misal ? SLVERR : OKAY;
        end
      end
      R_DATA: begin
        if (s_rready) begin
          rdst_d   = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rdst_d = R_IDLE;
    endcase
    arrdy_d = (rdst_d == R_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdst_q   <= R_IDLE;
      arrdy_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
    end else begin
      rdst_q   <= rdst_d;
      arrdy_q  <= arrdy_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
    end
  end

  axil_ram_mem #(
    .DataWidth (DataWidth),
    .MemDepth  (MemDepth)
  ) u_mem (
    .clk_i (clk_i),
    .we    (mem_we),
    .waddr (wa_addr[Lsb +: IdxW]),
    .wdata (wa_data),
    .re    (ar_hs),
    .raddr (s_araddr[Lsb +: IdxW]),
    .rdata (mem_rdata)
  );

  // Read data is forced to zero outside a valid OKAY beat, which also
  // hides the unreset RAM output register during reset.
  assign s_awready = awrdy_q;
  assign s_wready  = wrdy_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arrdy_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = (rvalid_q && rresp_q == OKAY) ? mem_rdata : '0;

  logic unused_bits;
  assign unused_bits = ^{s_awprot, s_arprot, wa_addr, s_araddr};

endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: directed scenarios plus random traffic
// checked against an array model of the RAM.
module tb_axil_ram_slave;
  import axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MD = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic arvalid = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  axil_ram_slave #(
    .DataWidth    (DW),
    .AddressWidth (AW),
    .MemDepth     (MD)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_awvalid (awvalid),
    .s_awready (awready),
    .s_awaddr  (awaddr),
    .s_awprot  (awprot),
    .s_wvalid  (wvalid),
    .s_wready  (wready),
    .s_wdata   (wdata),
    .s_wstrb   (wstrb),
    .s_bvalid  (bvalid),
    .s_bready  (bready),
    .s_bresp   (bresp),
    .s_arvalid (arvalid),
    .s_arready (arready),
    .s_araddr  (araddr),
    .s_arprot  (arprot),
    .s_rvalid  (rvalid),
    .s_rready  (rready),
    .s_rdata   (rdata),
    .s_rresp   (rresp)
  );

  logic [31:0] model [MD];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    if (a[1:0] == 2'b00)
      for (int i = 0; i < 4; i++)
        if (s[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic check_zero(input string tag);
    check(tag, 64'({awready, wready, bvalid, bresp, arready,
                    rvalid, rdata, rresp}), 64'(0));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, input int b_dly,
                          input string tag);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    logic [1:0] exp_resp;
    aw_done = 0;
    w_done = 0;
    cyc = 0;
    exp_resp = (a[1:0] != 0) ? 2'b10 : 2'b00;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && cyc >= aw_dly;
      awaddr = a;
      awprot = 3'($urandom);
      wvalid = !w_done && cyc >= w_dly;
      wdata = d;
      wstrb = s;
      if (w_done) check({tag, "/wready_held"}, 64'(wready), 64'(0));
      if (aw_done) check({tag, "/awready_held"}, 64'(awready), 64'(0));
      aw_fire = awvalid && awready;
      w_fire = wvalid && wready;
      @(posedge clk);
      #1;
      aw_done = aw_done || aw_fire;
      w_done = w_done || w_fire;
      cyc++;
    end
    awvalid = 0;
    wvalid = 0;
    check({tag, "/handshakes"}, 64'({aw_done, w_done}), 64'(2'b11));
    check({tag, "/bvalid"}, 64'(bvalid), 64'(1));
    check({tag, "/bresp"}, 64'(bresp), 64'(exp_resp));
    model_write(a, d, s);
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk);
      #1;
      check({tag, "/bp_hold"}, 64'({bvalid, bresp, awready, wready}),
            64'({1'b1, exp_resp, 2'b00}));
    end
    bready = 1;
    @(posedge clk);
    #1;
    bready = 0;
    check({tag, "/b_done"}, 64'({bvalid, awready, wready}), 64'(3'b011));
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly,
                         input string tag, output logic [31:0] got);
    bit fire;
    int cyc;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    exp_d = (a[1:0] != 0) ? 32'h0 : model[widx(a)];
    exp_r = (a[1:0] != 0) ? 2'b10 : 2'b00;
    arvalid = 1;
    araddr = a;
    arprot = 3'($urandom);
    fire = 0;
    cyc = 0;
    while (cyc < 20) begin
      fire = arready;
      @(posedge clk);
      #1;
      cyc++;
      if (fire) break;
    end
    arvalid = 0;
    check({tag, "/ar_fire"}, 64'(fire), 64'(1));
    check({tag, "/rvalid"}, 64'(rvalid), 64'(1));
    check({tag, "/rdata"}, 64'(rdata), 64'(exp_d));
    check({tag, "/rresp"}, 64'(rresp), 64'(exp_r));
    got = rdata;
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk);
      #1;
      check({tag, "/bp_hold"}, 64'({rvalid, rdata, rresp, arready}),
            64'({1'b1, exp_d, exp_r, 1'b0}));
    end
    rready = 1;
    @(posedge clk);
    #1;
    rready = 0;
    check({tag, "/r_done"}, 64'({rvalid, arready}), 64'(2'b01));
  endtask

  initial begin
    logic [31:0] got, a;
    logic [3:0] s;

    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst_n = 1;
    check({"readys_before_edge"}, 64'({awready, wready, arready}), 64'(0));
    @(posedge clk);
    #1;
    check("readys_after_edge", 64'({awready, wready, arready}), 64'(3'b111));

    for (int i = 0; i < 16; i++)
      do_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0, "init");
    do_write(32'h20, 32'h0, 4'hF, 0, 0, 0, "init_zero");

    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, "aw_w_same");
    do_read(32'h10, 0, "rd_deadbeef", got);
    check("rd_deadbeef/const", 64'(got), 64'(32'hDEADBEEF));

    do_write(32'h10, 32'h11223344, 4'h5, 3, 0, 0, "w_before_aw");
    do_read(32'h10, 0, "rd_merge", got);
    check("rd_merge/const", 64'(got), 64'(32'hDE22BE44));

    do_write(32'h13, 32'hFFFFFFFF, 4'hF, 0, 0, 0, "misal_wr");
    do_read(32'h10, 0, "misal_unchanged", got);
    check("misal_unchanged/const", 64'(got), 64'(32'hDE22BE44));
    do_read(32'h13, 0, "misal_rd", got);

    do_write(32'h14, 32'h5A5A0F0F, 4'hF, 0, 1, 4, "bp_write");
    do_read(32'h14, 4, "bp_read", got);

    awvalid = 1; awaddr = 32'h20;
    wvalid = 1; wdata = 32'hAAAA5555; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h20;
    @(posedge clk);
    #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("collide/b_r_valid", 64'({bvalid, rvalid}), 64'(2'b11));
    check("collide/old_data", 64'(rdata), 64'(0));
    model_write(32'h20, 32'hAAAA5555, 4'hF);
    bready = 1; rready = 1;
    @(posedge clk);
    #1;
    bready = 0; rready = 0;
    do_read(32'h20, 0, "collide_after", got);
    check("collide_after/const", 64'(got), 64'(32'hAAAA5555));

    awvalid = 1; awaddr = 32'h24;
    wvalid = 1; wdata = 32'h0BADCAFE; wstrb = 4'hF;
    @(posedge clk);
    #1;
    awvalid = 0; wvalid = 0;
    check("rst_b/bvalid", 64'(bvalid), 64'(1));
    model_write(32'h24, 32'h0BADCAFE, 4'hF);
    #2 rst_n = 0;
    #1 check_zero("rst_b/outputs");
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    check("rst_b/readys", 64'({awready, wready, arready, bvalid}),
          64'(4'b1110));

    awvalid = 1; awaddr = 32'h18;
    @(posedge clk);
    #1;
    awvalid = 0;
    check("rst_aw/held", 64'({awready, wready}), 64'(2'b01));
    #2 rst_n = 0;
    #1 check_zero("rst_aw/outputs");
    wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(posedge clk);
    #1;
    wvalid = 0;
    rst_n = 1;
    check("rst_aw/readys_low", 64'({awready, wready, arready}), 64'(0));
    @(posedge clk);
    #1;
    check("rst_aw/readys", 64'({awready, wready, arready}), 64'(3'b111));
    do_read(32'h18, 0, "rst_aw/no_write", got);
    do_read(32'h24, 0, "rst_b/kept", got);

    for (int n = 0; n < 60; n++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      s = 4'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, s, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), "rnd_wr");
      else
        do_read(a, $urandom_range(0, 2), "rnd_rd", got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
